// File: rtl/rtc_pkg.sv
// Stopwatch control state encoding and per-state datapath strobes,
// shared with the timer, counter and display blocks that decode o_state.
package rtc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    typedef struct packed {
        logic count_init;
        logic count_enb;
        logic latch_count;
    } ctrl_t;

    // Strobe pattern each state drives onto the datapath
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '{count_init: 1'b0, count_enb: 1'b0, latch_count: 1'b1};
        case (s)
            IDLE:    c.count_init = 1'b1;
            RUN:     c.count_enb  = 1'b1;
            PAUSE:   c.count_enb  = 1'b0;
            LAP:     begin
                c.count_enb   = 1'b1;
                c.latch_count = 1'b0;
            end
            default: c.count_init = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rtc_debounce.sv
// Two-flop synchroniser plus debouncer for one raw push button; emits the
// accepted stable level and a one-cycle pulse on each accepted press.
module rtc_debounce #(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic i_sclk,
    input  logic i_reset_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Level flips on the cycle the sample has disagreed DB_CYCLES times in a row
    always_ff @(posedge i_sclk) begin
        if (!i_reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            o_level <= 1'b0;
            o_press <= 1'b0;
        end else begin
            sync1   <= i_raw;
            sync2   <= sync1;
            o_press <= 1'b0;
            if (sync2 == o_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt     <= '0;
                o_level <= sync2;
                o_press <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rtc_trigger_ctrl.sv
// Two-button stopwatch controller: start/stop and lap/clear buttons drive the
// mode FSM, which registers the timer/counter/display control strobes.
module rtc_trigger_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = 1000000,
    parameter int unsigned HOLD_CYCLES = 200000000
) (
    input  logic       i_sclk,
    input  logic       i_reset_n,
    input  logic       i_trigger,
    input  logic       i_lap,
    output logic       o_count_init,
    output logic       o_count_enb,
    output logic       o_latch_count,
    output logic [1:0] o_state,
    output logic       o_lap_pulse
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hold_cnt;
    logic          trig_level_unused;
    logic          trig_press;
    logic          lap_level;
    logic          lap_press;
    logic          hold_active_c;
    logic          clear_c;

    rtc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_trigger (
        .i_sclk    (i_sclk),
        .i_reset_n (i_reset_n),
        .i_raw     (i_trigger),
        .o_level   (trig_level_unused),
        .o_press   (trig_press)
    );

    rtc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .i_sclk    (i_sclk),
        .i_reset_n (i_reset_n),
        .i_raw     (i_lap),
        .o_level   (lap_level),
        .o_press   (lap_press)
    );

    // Long-press clear fires once, on the cycle the hold count reaches its limit
    assign hold_active_c = (state == PAUSE) && lap_level;
    assign clear_c       = hold_active_c && (hold_cnt == HOLD_LAST);

    // Start press outranks both lap press and long-press clear
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (trig_press) state_nxt = RUN;
            RUN:   if (trig_press) state_nxt = PAUSE;
                   else if (lap_press) state_nxt = LAP;
            PAUSE: if (trig_press) state_nxt = RUN;
                   else if (clear_c) state_nxt = IDLE;
            LAP:   if (trig_press) state_nxt = PAUSE;
                   else if (lap_press) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_sclk) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            o_count_init  <= 1'b1;
            o_count_enb   <= 1'b0;
            o_latch_count <= 1'b1;
            o_lap_pulse   <= 1'b0;
        end else begin
            state <= state_nxt;
            {o_count_init, o_count_enb, o_latch_count} <= state_ctrl(state_nxt);
            o_lap_pulse <= (state_nxt == LAP) && (state != LAP);
            if (!hold_active_c || trig_press) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_rtc_trigger_ctrl.sv
// Bench for rtc_trigger_ctrl: directed scenarios plus random button activity,
// checked cycle by cycle against a behavioural stopwatch model.
module tb_rtc_trigger_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig  = 1'b0;
    logic       lapb  = 1'b0;
    logic       count_init;
    logic       count_enb;
    logic       latch_count;
    logic [1:0] state;
    logic       lap_pulse;

    int checks = 0;
    int errors = 0;

    rtc_trigger_ctrl #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
        .i_sclk        (clk),
        .i_reset_n     (rst_n),
        .i_trigger     (trig),
        .i_lap         (lapb),
        .o_count_init  (count_init),
        .o_count_enb   (count_enb),
        .o_latch_count (latch_count),
        .o_state       (state),
        .o_lap_pulse   (lap_pulse)
    );

    always #5 clk = ~clk;

    // Behavioural model: states 0 idle, 1 run, 2 pause, 3 lap
    int       m_state = 0;
    bit [1:0] ms_t = '0, ms_l = '0;
    bit       ml_t = 0, ml_l = 0, mp_t = 0, mp_l = 0, m_pulse = 0;
    int       mr_t = 0, mr_l = 0, m_hold = 0;
    int       start_next[4] = '{1, 2, 1, 2};
    int       lap_next[4]   = '{0, 3, 2, 1};

    function automatic logic [5:0] exp_vec();
        return {2'(m_state), 1'(m_state == 0), 1'(m_state == 1 || m_state == 3),
                1'(m_state != 3), m_pulse};
    endfunction

    function automatic logic [5:0] obs_vec();
        return {state, count_init, count_enb, latch_count, lap_pulse};
    endfunction

    task automatic deb(input bit pin, inout bit [1:0] s, inout bit lvl, inout int run,
                       inout bit pend);
        bit sample;
        sample = s[1];
        s      = {s[0], pin};
        pend   = 1'b0;
        if (sample != lvl) begin
            run++;
            if (run == DB) begin
                lvl  = sample;
                run  = 0;
                pend = sample;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_edge();
        int nxt, hn;
        bit qual, clr;
        if (!rst_n) begin
            m_state = 0; ms_t = '0; ms_l = '0; ml_t = 0; ml_l = 0;
            mr_t = 0; mr_l = 0; mp_t = 0; mp_l = 0; m_hold = 0; m_pulse = 0;
            return;
        end
        qual = (m_state == 2) && ml_l;
        hn   = qual ? ((m_hold + 1 > HOLD) ? HOLD : m_hold + 1) : 0;
        clr  = qual && (hn == HOLD) && (m_hold < HOLD);
        if (mp_t)      nxt = start_next[m_state];
        else if (clr)  nxt = 0;
        else if (mp_l) nxt = lap_next[m_state];
        else           nxt = m_state;
        if (mp_t && m_state == 2) hn = 0;
        m_pulse = (nxt == 3) && (m_state != 3);
        m_state = nxt;
        m_hold  = hn;
        deb(trig, ms_t, ml_t, mr_t, mp_t);
        deb(lapb, ms_l, ml_l, mr_l, mp_l);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_buttons(input bit t, input bit l, input int n, input string tag);
        trig = t;
        lapb = l;
        for (int i = 0; i < n; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL %s cycle %0d: got %b want %b", tag, i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_vec() !== 6'b00_1_0_1_0) begin
                errors++;
                $display("FAIL reset cycle %0d: got %b want 001010", i, obs_vec());
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_glitch();
        drive_buttons(1'b1, 1'b0, 3, "glitch_high");
        drive_buttons(1'b0, 1'b0, 10, "glitch_low");
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL glitch_state: got %b want 00", state);
        end
    endtask

    task automatic test_start_latency();
        int n;
        trig = 1'b1;
        tick();
        n = 0;
        while (state !== 2'b01 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 6 || count_enb !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: got %0d edges enb=%b want 6 edges enb=1", n, count_enb);
        end
        drive_buttons(1'b1, 1'b0, 4, "start_hold");
        drive_buttons(1'b0, 1'b0, 8, "start_release");
    endtask

    task automatic test_sequence();
        bit        is_start[7] = '{1, 0, 0, 1, 1, 0, 1};
        bit [1:0]  want[7]     = '{2'b01, 2'b11, 2'b01, 2'b10, 2'b01, 2'b11, 2'b10};
        drive_buttons(1'b0, 1'b0, 1, "seq_pre");
        rst_n = 1'b0;
        drive_buttons(1'b0, 1'b0, 2, "seq_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_buttons(is_start[i], !is_start[i], DB + 3, "seq_press");
            drive_buttons(1'b0, 1'b0, DB + 4, "seq_release");
            checks++;
            if (state !== want[i] || latch_count !== (want[i] != 2'b11)) begin
                errors++;
                $display("FAIL seq_step %0d: got state %b latch %b want state %b", i, state,
                         latch_count, want[i]);
            end
        end
    endtask

    task automatic test_hold();
        int clears;
        logic [1:0] prev;
        drive_buttons(1'b0, 1'b1, 8, "hold_short");
        drive_buttons(1'b0, 1'b0, 8, "hold_short_rel");
        checks++;
        if (state !== 2'b10) begin
            errors++;
            $display("FAIL hold_short: got %b want 10", state);
        end
        clears = 0;
        lapb = 1'b1;
        for (int i = 0; i < 30; i++) begin
            prev = state;
            tick();
            if (prev == 2'b10 && state == 2'b00) clears++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL hold_long cycle %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (clears !== 1 || state !== 2'b00 || count_init !== 1'b1) begin
            errors++;
            $display("FAIL hold_clear: got %0d clears state %b want 1 clear state 00", clears,
                     state);
        end
        drive_buttons(1'b0, 1'b0, 8, "hold_release");
        drive_buttons(1'b1, 1'b0, DB + 3, "hold_start");
        drive_buttons(1'b0, 1'b0, DB + 4, "hold_start_rel");
        drive_buttons(1'b0, 1'b1, 30, "hold_in_run");
        drive_buttons(1'b0, 1'b0, 8, "hold_in_run_rel");
        checks++;
        if (state !== 2'b11) begin
            errors++;
            $display("FAIL hold_in_run: got %b want 11", state);
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        drive_buttons(1'b1, 1'b0, DB + 3, "sim_to_pause");
        drive_buttons(1'b0, 1'b0, DB + 4, "sim_to_pause_rel");
        drive_buttons(1'b1, 1'b0, DB + 3, "sim_to_run");
        drive_buttons(1'b0, 1'b0, DB + 4, "sim_to_run_rel");
        pulses = 0;
        trig = 1'b1;
        lapb = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == DB + 3) begin
                trig = 1'b0;
                lapb = 1'b0;
            end
            pulses += int'(lap_pulse);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL simultaneous cycle %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (state !== 2'b10 || pulses !== 0) begin
            errors++;
            $display("FAIL simultaneous_end: got state %b pulses %0d want 10 and 0", state, pulses);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        drive_buttons(1'b1, 1'b0, DB + 3, "rm_run");
        drive_buttons(1'b0, 1'b0, DB + 4, "rm_run_rel");
        drive_buttons(1'b0, 1'b1, DB + 3, "rm_lap");
        drive_buttons(1'b0, 1'b0, DB + 4, "rm_lap_rel");
        drive_buttons(1'b1, 1'b0, 3, "rm_trig_partial");
        rst_n = 1'b0;
        tick();
        checks++;
        if (obs_vec() !== 6'b00_1_0_1_0) begin
            errors++;
            $display("FAIL reset_mid: got %b want 001010", obs_vec());
        end
        rst_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (state !== 2'b01 && n < 20);
        checks++;
        if (n !== DB + 3) begin
            errors++;
            $display("FAIL reset_mid_latency: got %0d edges want %0d", n, DB + 3);
        end
        drive_buttons(1'b0, 1'b0, 8, "rm_release");
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 80; seg++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            drive_buttons(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(1, 12), "random");
            rst_n = 1'b1;
            if ($urandom_range(0, 3) == 0) drive_buttons(1'b0, 1'($urandom_range(0, 1)),
                                                         $urandom_range(16, 24), "random_hold");
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_start_latency();
        test_sequence();
        test_hold();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtc_trigger_ctrl.md
# rtc_trigger_ctrl

Two-button stopwatch control block: debounces a start/stop button and a lap/clear button, runs the stopwatch mode FSM, and drives the control strobes for the 10-ms timer, the 24-bit counter and the display latch. Successor to the single-button trigger controller. Debounce and hold times are parametrised, pause truly stops counting, and the block adds lap (split) mode and long-press clear. Sits between the board push buttons and the timer/counter/display datapath.

## Interface
Parameters:
- DB_CYCLES, 1000000: consecutive stable cycles required to accept a button level change (≥1).
- HOLD_CYCLES, 200000000: cycles lap must be held (debounced) in PAUSE to clear (> DB_CYCLES).

Ports:
- i_sclk  in  1  system clock
- i_reset_n  in  1  synchronous, active-low reset
- i_trigger  in  1  start/stop button, raw and asynchronous
- i_lap  in  1  lap/clear button, raw and asynchronous
- o_count_init  out  1  clear timer and counter
- o_count_enb  out  1  timer/counter count enable
- o_latch_count  out  1  1 = display latch transparent (tracks count), 0 = display frozen
- o_state  out  2  current FSM state
- o_lap_pulse  out  1  one-cycle strobe on entry to LAP

## Operation
- Each button uses a 2-flop synchroniser and then a debouncer. The counter resets whenever the synchronised sample equals the stable level.
- The stable level flips on the edge where the sample has differed for DB_CYCLES consecutive cycles.
- Press event: one-cycle pulse on a stable 0→1 transition. Releases generate no event.
- States and outputs (init/enb/latch):
  - IDLE 1/0/1
  - RUN 0/1/1
  - PAUSE 0/0/1
  - LAP 0/1/0
- Transitions on start press:
  - IDLE→RUN
  - RUN→PAUSE
  - PAUSE→RUN
  - LAP→PAUSE (display then shows the final count)
- Transitions on lap press:
  - RUN→LAP
  - LAP→RUN
  - ignored in IDLE and PAUSE
- Hold counter:
  - Counts only while state is PAUSE and the lap stable level is 1. Otherwise it is 0.
  - On reaching HOLD_CYCLES it issues one clear event: PAUSE→IDLE.
  - It then saturates, giving no repeat until lap is released.
- Simultaneous start and lap press events in the same cycle: start wins, lap is discarded.
- Clear event coinciding with a start press: start wins (PAUSE→RUN), and the hold counter zeroes.
- o_lap_pulse asserts for exactly the cycle o_state first shows LAP.

## Timing
- Reset, sampled on the rising edge of i_sclk while i_reset_n=0:
  - state IDLE
  - o_count_init=1, o_count_enb=0, o_latch_count=1, o_lap_pulse=0, o_state=2'b00
  - stable levels 0, all counters 0
- Reset mid-debounce or mid-hold discards progress.
- Pin-to-event latency: an input held from before edge k yields a press event on edge k+1+DB_CYCLES (2 sync stages plus the debounce window).
- Outputs are registered: they change on the edge after the event (pin to output DB_CYCLES+2 edges).
- Glitches shorter than DB_CYCLES cycles produce no event and no output change.
- Counter widths: $clog2(DB_CYCLES+1) and $clog2(HOLD_CYCLES+1). The debounce counter never wraps.

## Structure
- Shared package rtc_pkg holds the state encoding: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11. The timer/counter/display blocks decode o_state with it.
- One sub-module, rtc_debounce (parameter DB_CYCLES; ports i_sclk, i_reset_n, i_raw, o_level, o_press), instantiated once per button.
- FSM and hold counter live in the top.

## Test plan
Use DB_CYCLES=4, HOLD_CYCLES=16.
- Reset asserted 3 cycles → o_state=00, init=1, enb=0, latch=1, lap_pulse=0 on the first reset edge and held.
- i_trigger high 3 cycles then low → no state change. High 10 cycles → o_state=01 (RUN), enb=1, exactly 6 edges after the first high sample.
- Sequence start, lap, lap, start, start, lap, start → states RUN, LAP (lap_pulse one cycle, latch=0), RUN, PAUSE (enb=0), RUN, LAP, PAUSE (latch=1).
- In PAUSE, lap held 8 cycles → stays PAUSE. Held 30 cycles → IDLE once (init=1), no further event until release. Lap held in RUN 30 cycles → LAP only.
- In RUN, both buttons pressed on the same cycle → PAUSE, lap_pulse stays 0.
- Reset asserted during LAP and mid-debounce of i_trigger → IDLE outputs on the next edge. After release, the button still held must require a full DB_CYCLES before any event.
